// File: rtl/inner_fn_sched.sv
// Two-requester round-robin scheduler sharing one fixed-latency datapath, with per-requester result FIFOs.
// Define INNER_FN_SCHED_CHECK_EN to enable the sticky pipe_done latency-mismatch flag on err.
module inner_fn_sched #(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              clk_en,
  input  logic              req_a_valid,
  input  logic [DATA_W-1:0] req_a_data,
  output logic              req_a_ready,
  input  logic              req_b_valid,
  input  logic [DATA_W-1:0] req_b_data,
  output logic              req_b_ready,
  output logic              rsp_a_valid,
  output logic [DATA_W-1:0] rsp_a_data,
  input  logic              rsp_a_ready,
  output logic              rsp_b_valid,
  output logic [DATA_W-1:0] rsp_b_data,
  input  logic              rsp_b_ready,
  output logic              pipe_start,
  output logic [DATA_W-1:0] pipe_dataa,
  input  logic [DATA_W-1:0] pipe_result,
  input  logic              pipe_done,
  output logic              busy,
  output logic              err
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW     = PTR_W + 1;
  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);

  logic               r_last_b;
  logic               r_pipe_start;
  logic               r_pipe_owner;
  logic [DATA_W-1:0]  r_pipe_dataa;
  logic [LATENCY-1:0] r_tag_v;
  logic [LATENCY-1:0] r_tag_id;

  logic [1:0]         w_valid;
  logic [1:0]         w_rsp_ready;
  logic [1:0]         w_has_cred;
  logic [1:0]         w_elig;
  logic [1:0]         w_grant;
  logic [1:0]         w_rsp_valid;
  logic [DATA_W-1:0]  w_head [2];

  assign w_valid     = {req_b_valid, req_a_valid};
  assign w_rsp_ready = {rsp_b_ready, rsp_a_ready};

  // Round robin: r_last_b=1 means B was granted last, so A wins a tie.
  assign w_elig     = {2{!aclr && clk_en}} & w_valid & w_has_cred;
  assign w_grant[0] = w_elig[0] && (!w_elig[1] || r_last_b);
  assign w_grant[1] = w_elig[1] && (!w_elig[0] || !r_last_b);

  assign req_a_ready = w_grant[0];
  assign req_b_ready = w_grant[1];
  assign rsp_a_valid = w_rsp_valid[0];
  assign rsp_b_valid = w_rsp_valid[1];
  assign rsp_a_data  = w_head[0];
  assign rsp_b_data  = w_head[1];
  assign pipe_start  = r_pipe_start;
  assign pipe_dataa  = r_pipe_dataa;
  assign busy        = r_pipe_start | (|r_tag_v);

  // Issue register and owner-tag shift line; the last stage lines up with pipe_done.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_last_b     <= 1'b1;
      r_pipe_start <= 1'b0;
      r_pipe_owner <= 1'b0;
      r_pipe_dataa <= '0;
      r_tag_v      <= '0;
      r_tag_id     <= '0;
    end else if (clk_en) begin
      r_pipe_start <= |w_grant;
      if (|w_grant) begin
        r_last_b     <= w_grant[1];
        r_pipe_owner <= w_grant[1];
        r_pipe_dataa <= w_grant[1] ? req_b_data : req_a_data;
      end
      r_tag_v  <= {r_tag_v[LATENCY-2:0], r_pipe_start};
      r_tag_id <= {r_tag_id[LATENCY-2:0], r_pipe_owner};
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_req
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [CRED_W-1:0] r_cred;
    logic              w_push;
    logic              w_pop;

    assign w_push         = clk_en && r_tag_v[LATENCY-1] && (r_tag_id[LATENCY-1] == 1'(g));
    assign w_pop          = clk_en && w_rsp_valid[g] && w_rsp_ready[g];
    assign w_rsp_valid[g] = (r_wr != r_rd);
    assign w_head[g]      = r_mem[r_rd[PTR_W-1:0]];
    assign w_has_cred[g]  = (r_cred != '0);

    // Credits reserve a FIFO slot at acceptance, so a push can never find the FIFO full.
    always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
        r_wr   <= '0;
        r_rd   <= '0;
        r_cred <= CRED_W'(FIFO_DEPTH);
        for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr[PTR_W-1:0]] <= pipe_result;
          r_wr                   <= r_wr + PW'(1);
        end
        if (w_pop) r_rd <= r_rd + PW'(1);
        if (w_grant[g] && !w_pop)      r_cred <= r_cred - CRED_W'(1);
        else if (w_pop && !w_grant[g]) r_cred <= r_cred + CRED_W'(1);
      end
    end
  end

`ifdef INNER_FN_SCHED_CHECK_EN
  logic r_err;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr)                                          r_err <= 1'b0;
    else if (clk_en && (pipe_done != r_tag_v[LATENCY-1])) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  logic w_unused_done;

  assign w_unused_done = pipe_done;
  assign err           = 1'b0;
`endif

endmodule
